mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width in bits.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_start  input  1  request to launch the operation on i_op.
REQ-005 SHALL have port i_op  input  3  opcode: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 SHALL have port i_a  input  WIDTH  rs operand, driven from register-file read port 1.
REQ-007 SHALL have port i_b  input  WIDTH  rt operand, driven from register-file read port 2.
REQ-008 SHALL have port o_busy  output  1  multi-cycle operation in progress.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse when HI/LO update.
REQ-010 SHALL have port o_hi  output  WIDTH  HI register.
REQ-011 SHALL have port o_lo  output  WIDTH  LO register.

Function
REQ-012 SHALL accept i_start only when o_busy=0; i_start while o_busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-013 SHALL latch i_op, i_a and i_b on the accepting edge; later operand changes SHALL NOT affect the result.
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX: IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU; MUL or DIV->FIX after 32 iteration edges; FIX->IDLE after one edge.
REQ-015 SHALL drive o_busy=1 in MUL, DIV and FIX, and o_busy=0 in IDLE.
REQ-016 SHALL compute MULT/MULTU iteratively (one partial-product bit per edge) and write the 64-bit product to HI (upper) and LO (lower).
REQ-017 SHALL compute DIV/DIVU by restoring division (one quotient bit per edge) and write the quotient to LO and the remainder to HI.
REQ-018 SHALL handle signed operations as magnitude iteration plus sign correction in FIX: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-019 SHALL give the following latency: operation accepted at edge 0; HI/LO written and o_done=1 after edge 33; o_busy=0 after edge 33.
REQ-020 SHALL write MTHI/MTLO (i_a into HI or LO) on the accepting edge, pulse o_done for the following cycle, and leave o_busy at 0.
REQ-021 SHALL, on divide by zero, take full latency and produce HI=dividend and LO=all ones.
REQ-022 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-023 SHALL treat reserved opcodes as no-ops: no o_done pulse, HI/LO unchanged.
REQ-024 SHALL keep HI/LO stable except at the completion edge or an MTHI/MTLO edge.

Reset
REQ-025 SHALL, while i_rst=1, immediately force o_hi=0, o_lo=0, o_busy=0, o_done=0 and FSM state IDLE, independent of i_clk.
REQ-026 SHALL, on reset mid-operation, abort the operation, discard the partial result, and accept a new i_start on the first edge after i_rst deasserts.

Configuration
REQ-027 SHALL compile the divider (DIV state, REQ-017/018/021/022) only when macro MUL_DIV_UNIT_DIV_EN is defined.
REQ-028 SHALL, without MUL_DIV_UNIT_DIV_EN, treat DIV/DIVU as: o_busy stays 0, o_done pulses the cycle after acceptance, HI/LO unchanged; multiply and MTHI/MTLO behave identically in both builds.

Verification
REQ-029 SHALL cover: MULT a=0xFFFFFFFF, b=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, o_done after edge 33 only.
REQ-030 SHALL cover: MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 SHALL cover (macro defined): DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
REQ-032 SHALL cover: MULT started, second i_start at edge 5 ignored, i_rst pulsed at cycle 10 -> HI=LO=0, o_busy=0, no o_done; a new MULTU 3*4 -> LO=12, HI=0.
REQ-033 SHALL cover: MTHI a=0x12345678 -> o_hi=0x12345678 after one edge, o_done one cycle, o_busy never 1; then MTLO a=0xCAFEF00D -> o_lo=0xCAFEF00D.
REQ-034 SHALL cover (macro undefined): DIV a=10, b=3 -> o_done the next cycle, o_busy=0, HI/LO hold prior values.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit.
//
// Multiplies by shift-and-add and divides by restoring division, one result
// bit per clock edge on unsigned magnitudes. A final FIX cycle applies the
// sign correction and writes HI/LO. MTHI/MTLO write HI/LO directly on the
// accepting edge.
//
// Optional feature macro: MUL_DIV_UNIT_DIV_EN
//   defined   - divider built (DIV state, DIV/DIVU produce quotient/remainder)
//   undefined - DIV/DIVU only pulse o_done the cycle after acceptance
//
// Ports
//   i_clk    in   1      clock, rising edge
//   i_rst    in   1      asynchronous active-high reset
//   i_start  in   1      launch i_op (ignored while o_busy)
//   i_op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                        100 MTHI, 101 MTLO, 11x reserved (no-op)
//   i_a      in   WIDTH  rs operand
//   i_b      in   WIDTH  rt operand
//   o_busy   out  1      multi-cycle operation in progress
//   o_done   out  1      one-cycle pulse after HI/LO update
//   o_hi     out  WIDTH  HI register
//   o_lo     out  WIDTH  LO register
//
// state  | meaning
// IDLE   | waiting for i_start
// MUL    | shift-and-add, one multiplier bit per edge
// DIV    | restoring division, one quotient bit per edge
// FIX    | sign correction, HI/LO write, o_done pulse next cycle

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MUL_DIV_UNIT_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_FIX  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_prod;    // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     r_b;       // multiplicand / divisor magnitude
  logic                 r_neg_q;   // negate product or quotient in FIX
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic [WIDTH:0]       w_sum;
  logic                 w_cnt_zero;
`ifdef MUL_DIV_UNIT_DIV_EN
  logic                 r_is_div;
  logic                 r_neg_r;   // remainder follows dividend sign
  logic                 r_dz;      // divide by zero: LO forced to all ones
  logic [WIDTH:0]       w_trial;
`endif

  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  assign w_cnt_zero = (r_cnt == '0);

  // One shift-and-add step: add multiplicand to the upper half when the
  // current multiplier bit is set, then shift the whole pair right.
  always_comb begin
    w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_b} : '0);
  end

`ifdef MUL_DIV_UNIT_DIV_EN
  // Trial subtraction of the divisor from {remainder, next dividend bit};
  // w_trial[WIDTH] set means borrow, i.e. restore.
  always_comb begin
    w_trial = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]} - {1'b0, r_b};
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_op == OP_MULT || i_op == OP_MULTU) begin
            w_state_nxt = S_MUL;
          end
`ifdef MUL_DIV_UNIT_DIV_EN
          else if (i_op == OP_DIV || i_op == OP_DIVU) begin
            w_state_nxt = S_DIV;
          end
`endif
        end
      end
      S_MUL: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_FIX;
        end
      end
`ifdef MUL_DIV_UNIT_DIV_EN
      S_DIV: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_FIX;
        end
      end
`endif
      S_FIX: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            case (i_op)
              OP_MULT, OP_MULTU: begin
                // Signed ops have i_op[0] == 0.
                r_b     <= f_mag(i_a, ~i_op[0]);
                r_prod  <= {{WIDTH{1'b0}}, f_mag(i_b, ~i_op[0])};
                r_neg_q <= ~i_op[0] & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_cnt   <= CW'(WIDTH - 1);
`ifdef MUL_DIV_UNIT_DIV_EN
                r_is_div <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                r_b      <= f_mag(i_b, ~i_op[0]);
                r_prod   <= {{WIDTH{1'b0}}, f_mag(i_a, ~i_op[0])};
                r_neg_q  <= ~i_op[0] & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                r_neg_r  <= ~i_op[0] & i_a[WIDTH-1];
                r_dz     <= (i_b == '0);
                r_is_div <= 1'b1;
                r_cnt    <= CW'(WIDTH - 1);
`else
                r_done <= 1'b1;
`endif
              end
              OP_MTHI: begin
                r_hi   <= i_a;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= i_a;
                r_done <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        S_MUL: begin
          r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt - 1'b1;
        end
`ifdef MUL_DIV_UNIT_DIV_EN
        S_DIV: begin
          if (!w_trial[WIDTH]) begin
            r_prod <= {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
          end else begin
            r_prod <= {r_prod[2*WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - 1'b1;
        end
`endif
        S_FIX: begin
          r_done <= 1'b1;
`ifdef MUL_DIV_UNIT_DIV_EN
          if (r_is_div) begin
            // Negating the remainder magnitude restores the original
            // dividend on divide by zero, so HI needs no special case.
            r_hi <= r_neg_r ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_dz ? '1 : (r_neg_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0]);
          end else begin
            {r_hi, r_lo} <= r_neg_q ? -r_prod : r_prod;
          end
`else
          {r_hi, r_lo} <= r_neg_q ? -r_prod : r_prod;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] f_ref(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2, 3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
        return {r[31:0], q[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Behavioural model: edges remaining until completion plus pending result.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_done = 1'b0;
  logic [63:0] m_res = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_res;
          m_done = 1'b1;
        end
      end else if (i_start) begin
        case (i_op)
          3'd0, 3'd1: begin
            m_res  = f_ref(i_op, i_a, i_b);
            m_left = 33;
          end
          3'd2, 3'd3: begin
`ifdef MUL_DIV_UNIT_DIV_EN
            m_res  = f_ref(i_op, i_a, i_b);
            m_left = 33;
`else
            m_done = 1'b1;
`endif
          end
          3'd4: begin
            m_hi   = i_a;
            m_done = 1'b1;
          end
          3'd5: begin
            m_lo   = i_a;
            m_done = 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'd0, o_busy}, {63'd0, (m_left > 0)});
    chk("done", {63'd0, o_done}, {63'd0, m_done});
    chk("hi", {32'd0, o_hi}, {32'd0, m_hi});
    chk("lo", {32'd0, o_lo}, {32'd0, m_lo});
  end

  // Wait for the model to go idle, throwing ignored starts and operand
  // changes at the DUT meanwhile. Called at posedge+1.
  task automatic wait_idle();
    int n;
    n = 0;
    while (m_left != 0) begin
      if (n > 60) begin
        n_checks++;
        n_errors++;
        $display("FAIL timeout: still busy after %0d cycles, required idle", n);
        i_start = 1'b0;
        return;
      end
      i_start = 1'($urandom_range(0, 1));
      i_op    = 3'($urandom_range(0, 7));
      i_a     = $urandom;
      i_b     = $urandom;
      @(posedge clk);
      #1;
      n++;
    end
    i_start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
    wait_idle();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, o_hi}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    rst = 1'b0;

    chk("pin_mult", f_ref(3'd0, 32'hFFFF_FFFF, 32'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_multu", f_ref(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    chk("pin_div", f_ref(3'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_divovf", f_ref(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    chk("pin_divz", f_ref(3'd3, 32'd7, 32'd0), 64'h0000_0007_FFFF_FFFF);

    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi", {32'd0, o_hi}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, o_lo}, 64'hFFFF_FFFE);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", {32'd0, o_hi}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, o_lo}, 64'h0000_0001);

    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", {32'd0, o_hi}, 64'h1234_5678);
    chk("mthi_done", {63'd0, o_done}, 64'd1);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", {32'd0, o_lo}, 64'hCAFE_F00D);

`ifdef MUL_DIV_UNIT_DIV_EN
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo", {32'd0, o_lo}, 64'hFFFF_FFFD);
    chk("div_hi", {32'd0, o_hi}, 64'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd0);
    chk("divz_hi", {32'd0, o_hi}, 64'h7);
    chk("divz_lo", {32'd0, o_lo}, 64'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divovf_lo", {32'd0, o_lo}, 64'h8000_0000);
    chk("divovf_hi", {32'd0, o_hi}, 64'h0);
`else
    issue(3'd2, 32'd10, 32'd3);
    chk("nodiv_done", {63'd0, o_done}, 64'd1);
    chk("nodiv_busy", {63'd0, o_busy}, 64'd0);
    chk("nodiv_hi", {32'd0, o_hi}, 64'h1234_5678);
    chk("nodiv_lo", {32'd0, o_lo}, 64'hCAFE_F00D);
`endif

    // Reset in the middle of a multiply.
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_op    = 3'd0;
    i_a     = 32'h0001_2345;
    i_b     = 32'h0000_0777;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    i_start = 1'b1;
    i_op    = 3'd1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("midrst_hi", {32'd0, o_hi}, 64'd0);
    chk("midrst_lo", {32'd0, o_lo}, 64'd0);
    chk("midrst_busy", {63'd0, o_busy}, 64'd0);
    chk("midrst_done", {63'd0, o_done}, 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    i_start = 1'b1;
    i_op    = 3'd1;
    i_a     = 32'd3;
    i_b     = 32'd4;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("postrst_busy", {63'd0, o_busy}, 64'd1);
    wait_idle();
    chk("postrst_lo", {32'd0, o_lo}, 64'd12);
    chk("postrst_hi", {32'd0, o_hi}, 64'd0);

    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
